pc_seq: RTL and testbench

- Parametrised program-counter sequencer for the RV32/RV64 fetch stage. It produces the fetch address IP and the link value PC_def.
- Stalls fetch for a configurable number of cycles while a control-flow instruction resolves, then takes the branch/jump or falls through.
- Adds to the previous generation: external pipeline hold, priority trap/redirect input, and a fault state for misaligned targets.

---
 rtl/pc_pkg.sv | 35 +++
 rtl/pc_target.sv | 36 +++
 rtl/signExtend.sv | 12 +
 rtl/pc_seq.sv | 123 ++++++++++++
 tb/tb_pc_seq.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

    localparam int CNT_W = 4;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CF_NONE = 2'd0,
        CF_JAL  = 2'd1,
        CF_JALR = 2'd2,
        CF_BR   = 2'd3
    } cf_class_e;

    // Map a decode opcode onto its control-flow class.
    function automatic cf_class_e classify(input logic [6:0] op);
        cf_class_e cls;
        case (op)
            OP_JAL:  cls = CF_JAL;
            OP_JALR: cls = CF_JALR;
            OP_BR:   cls = CF_BR;
            default: cls = CF_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/pc_target.sv
// Control-flow target selection and alignment check.
module pc_target
    import pc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4
) (
    input  cf_class_e         cls_i,
    input  logic [XLEN-1:0]   ip_i,
    input  logic [XLEN-1:0]   up_amt_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   imm_sext_i,
    output logic [XLEN-1:0]   target_o,
    output logic              misaligned_o
);

    // Number of low address bits that must be zero for a legal target.
    localparam int ALIGN_BITS = (IALIGN == 2) ? 1 : 2;

    logic [XLEN-1:0] jalr_sum_s;

    assign jalr_sum_s = rs1_i + imm_sext_i;

    // JALR uses register-relative address with bit0 forced low; others are PC-relative.
    always_comb begin
        target_o = ip_i + up_amt_i;
        if (cls_i == CF_JALR) begin
            target_o = {jalr_sum_s[XLEN-1:1], 1'b0};
        end else begin
            target_o = ip_i + up_amt_i;
        end
    end

    assign misaligned_o = |target_o[ALIGN_BITS-1:0];

endmodule

// File: rtl/signExtend.sv
// Sign-extends an N-bit field to MAX bits.
module signExtend #(
    parameter int N   = 12,
    parameter int MAX = 32
) (
    input  logic [N-1:0]   in_i,
    output logic [MAX-1:0] out_o
);

    assign out_o = {{(MAX-N){in_i[N-1]}}, in_i};

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: fetch address generation with CF resolve wait,
// pipeline hold, priority redirect and misaligned-target fault.
module pc_seq
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              RESOLVE_CYC = 1,
    parameter int              IALIGN      = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            hold,
    input  logic [6:0]      OP,
    input  logic            b_taken,
    input  logic [XLEN-1:0] up_amt,
    input  logic [XLEN-1:0] RS1_DATA,
    input  logic [11:0]     immm,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] IP,
    output logic [XLEN-1:0] PC_def,
    output logic            fetch_valid,
    output logic            misalign,
    output logic [XLEN-1:0] fault_addr
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESOLVE_CYC - 1);

    state_e          state_q;
    cf_class_e       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] ip_q;
    logic [XLEN-1:0] fault_addr_q;
    logic            misalign_q;

    cf_class_e       cls_s;
    logic [XLEN-1:0] ip_plus4_s;
    logic [XLEN-1:0] imm_sext_s;
    logic [XLEN-1:0] target_s;
    logic            misaligned_s;
    logic            taken_s;

    assign cls_s      = classify(OP);
    assign ip_plus4_s = ip_q + XLEN'(4);
    assign taken_s    = (op_q == CF_JAL) | (op_q == CF_JALR) | ((op_q == CF_BR) & b_taken);

    signExtend #(.N(12), .MAX(XLEN)) u_sext (
        .in_i  (immm),
        .out_o (imm_sext_s)
    );

    pc_target #(.XLEN(XLEN), .IALIGN(IALIGN)) u_target (
        .cls_i        (op_q),
        .ip_i         (ip_q),
        .up_amt_i     (up_amt),
        .rs1_i        (RS1_DATA),
        .imm_sext_i   (imm_sext_s),
        .target_o     (target_s),
        .misaligned_o (misaligned_s)
    );

    // Sequencer FSM: redirect beats hold beats normal RUN/WAIT/FAULT progress.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ip_q         <= RESET_VEC;
            state_q      <= RUN;
            cnt_q        <= '0;
            op_q         <= CF_NONE;
            fault_addr_q <= '0;
            misalign_q   <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (redirect_valid) begin
                ip_q    <= redirect_pc;
                state_q <= RUN;
                cnt_q   <= '0;
            end else if (hold) begin
                state_q <= state_q;
            end else begin
                case (state_q)
                    RUN: begin
                        if (cls_s != CF_NONE) begin
                            op_q    <= cls_s;
                            cnt_q   <= CNT_LOAD;
                            state_q <= WAIT;
                        end else begin
                            ip_q <= ip_plus4_s;
                        end
                    end
                    WAIT: begin
                        if (cnt_q != {CNT_W{1'b0}}) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end else if (!taken_s) begin
                            ip_q    <= ip_plus4_s;
                            state_q <= RUN;
                        end else if (misaligned_s) begin
                            fault_addr_q <= target_s;
                            misalign_q   <= 1'b1;
                            state_q      <= FAULT;
                        end else begin
                            ip_q    <= target_s;
                            state_q <= RUN;
                        end
                    end
                    FAULT: begin
                        state_q <= FAULT;
                    end
                    default: begin
                        state_q <= RUN;
                    end
                endcase
            end
        end
    end

    assign IP          = ip_q;
    assign PC_def      = ip_plus4_s;
    assign fetch_valid = (state_q == RUN) & ~RESET;
    assign misalign    = misalign_q;
    assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: two instances with different resolve depth and alignment.
module tb_pc_seq;

    localparam logic [6:0] NOP  = 7'b0010011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] BR   = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic [6:0]  op = NOP;
    logic        b_taken = 1'b0;
    logic [31:0] up_amt = 32'h0;
    logic [31:0] rs1 = 32'h0;
    logic [11:0] immm = 12'h0;
    logic        rv = 1'b0;
    logic [31:0] rpc = 32'h0;

    logic [31:0] ip_a, pcd_a, fa_a, ip_b, pcd_b, fa_b;
    logic        fv_a, mis_a, fv_b, mis_b;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    // A: resolve depth 2, word alignment.
    pc_seq #(.XLEN(32), .RESET_VEC(32'h100), .RESOLVE_CYC(2), .IALIGN(4)) u_a (
        .CLK(clk), .RESET(rst), .hold(hold), .OP(op), .b_taken(b_taken),
        .up_amt(up_amt), .RS1_DATA(rs1), .immm(immm),
        .redirect_valid(rv), .redirect_pc(rpc),
        .IP(ip_a), .PC_def(pcd_a), .fetch_valid(fv_a), .misalign(mis_a), .fault_addr(fa_a)
    );

    // B: resolve depth 3, halfword alignment.
    pc_seq #(.XLEN(32), .RESET_VEC(32'h100), .RESOLVE_CYC(3), .IALIGN(2)) u_b (
        .CLK(clk), .RESET(rst), .hold(hold), .OP(op), .b_taken(b_taken),
        .up_amt(up_amt), .RS1_DATA(rs1), .immm(immm),
        .redirect_valid(rv), .redirect_pc(rpc),
        .IP(ip_b), .PC_def(pcd_b), .fetch_valid(fv_b), .misalign(mis_b), .fault_addr(fa_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] addr);
        rv  = 1'b1;
        rpc = addr;
        step();
        rv  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_ip;
        rst = 1'b1;
        step();
        step();
        vecs++; if (ip_a !== 32'h100) begin errs++; $display("FAIL rst_ip got=%h exp=%h", ip_a, 32'h100); end
        vecs++; if (fv_a !== 1'b0) begin errs++; $display("FAIL rst_fv got=%b exp=0", fv_a); end
        vecs++; if (mis_a !== 1'b0 || fa_a !== 32'h0) begin errs++; $display("FAIL rst_fault got=%b/%h exp=0/0", mis_a, fa_a); end
        vecs++; if (pcd_a !== 32'h104) begin errs++; $display("FAIL rst_pcdef got=%h exp=%h", pcd_a, 32'h104); end
        rst = 1'b0;
        op  = NOP;
        #1;
        exp_ip = 32'h100;
        for (int i = 0; i < 4; i++) begin
            vecs++; if (ip_a !== exp_ip || fv_a !== 1'b1) begin errs++; $display("FAIL seq%0d got=%h/%b exp=%h/1", i, ip_a, fv_a, exp_ip); end
            vecs++; if (ip_b !== exp_ip) begin errs++; $display("FAIL seq_b%0d got=%h exp=%h", i, ip_b, exp_ip); end
            step();
            exp_ip = exp_ip + 32'd4;
        end
    endtask

    task automatic test_branch(input logic tk, input logic [31:0] exp_ip);
        redirect_to(32'h200);
        op = BR; b_taken = tk; up_amt = 32'hFFFF_FFF8;
        vecs++; if (ip_a !== 32'h200 || fv_a !== 1'b1) begin errs++; $display("FAIL br%0d_detect got=%h/%b exp=200/1", tk, ip_a, fv_a); end
        step();
        op = NOP;
        for (int i = 0; i < 2; i++) begin
            vecs++; if (ip_a !== 32'h200 || fv_a !== 1'b0) begin errs++; $display("FAIL br%0d_wait%0d got=%h/%b exp=200/0", tk, i, ip_a, fv_a); end
            step();
        end
        vecs++; if (ip_a !== exp_ip || fv_a !== 1'b1) begin errs++; $display("FAIL br%0d_resolve got=%h/%b exp=%h/1", tk, ip_a, fv_a, exp_ip); end
        b_taken = 1'b0;
    endtask

    task automatic test_jalr_fault();
        redirect_to(32'h0);
        op = JALR; rs1 = 32'h1003; immm = 12'h004;
        step();
        op = NOP;
        step();
        step();
        vecs++; if (mis_a !== 1'b1) begin errs++; $display("FAIL jalr_mis_pulse got=%b exp=1", mis_a); end
        vecs++; if (fa_a !== 32'h1006) begin errs++; $display("FAIL jalr_fault_addr got=%h exp=%h", fa_a, 32'h1006); end
        vecs++; if (ip_a !== 32'h0 || fv_a !== 1'b0) begin errs++; $display("FAIL jalr_fault_ip got=%h/%b exp=0/0", ip_a, fv_a); end
        step();
        vecs++; if (mis_a !== 1'b0) begin errs++; $display("FAIL jalr_mis_one got=%b exp=0", mis_a); end
        vecs++; if (ip_b !== 32'h1006 || fv_b !== 1'b1 || mis_b !== 1'b0) begin errs++; $display("FAIL jalr_ialign2 got=%h/%b/%b exp=1006/1/0", ip_b, fv_b, mis_b); end
        step();
        step();
        vecs++; if (fv_a !== 1'b0 || ip_a !== 32'h0) begin errs++; $display("FAIL fault_persist got=%h/%b exp=0/0", ip_a, fv_a); end
        redirect_to(32'h80);
        vecs++; if (ip_a !== 32'h80 || fv_a !== 1'b1) begin errs++; $display("FAIL fault_exit got=%h/%b exp=80/1", ip_a, fv_a); end
    endtask

    task automatic test_hold();
        // Baseline without hold: new IP after 4 edges.
        redirect_to(32'h300);
        op = JAL; up_amt = 32'h40;
        step();
        op = NOP;
        step();
        step();
        vecs++; if (ip_b !== 32'h300) begin errs++; $display("FAIL jal_nohold_wait got=%h exp=300", ip_b); end
        step();
        vecs++; if (ip_b !== 32'h340) begin errs++; $display("FAIL jal_nohold got=%h exp=340", ip_b); end
        // Same with three held cycles mid-WAIT: resolves 3 edges later.
        redirect_to(32'h300);
        op = JAL;
        step();
        op = NOP;
        step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++; if (ip_b !== 32'h300 || fv_b !== 1'b0) begin errs++; $display("FAIL hold%0d got=%h/%b exp=300/0", i, ip_b, fv_b); end
        end
        hold = 1'b0;
        step();
        vecs++; if (ip_b !== 32'h300) begin errs++; $display("FAIL hold_late got=%h exp=300", ip_b); end
        step();
        vecs++; if (ip_b !== 32'h340 || fv_b !== 1'b1) begin errs++; $display("FAIL hold_resolve got=%h/%b exp=340/1", ip_b, fv_b); end
    endtask

    task automatic test_redirect_hold();
        redirect_to(32'h400);
        op = JAL; up_amt = 32'h40;
        step();
        op = NOP;
        hold = 1'b1; rv = 1'b1; rpc = 32'h500;
        step();
        rv = 1'b0; hold = 1'b0;
        vecs++; if (ip_b !== 32'h500 || fv_b !== 1'b1) begin errs++; $display("FAIL redir_hold got=%h/%b exp=500/1", ip_b, fv_b); end
        vecs++; if (ip_a !== 32'h500 || fv_a !== 1'b1) begin errs++; $display("FAIL redir_hold_a got=%h/%b exp=500/1", ip_a, fv_a); end
        step();
        vecs++; if (ip_b !== 32'h504) begin errs++; $display("FAIL redir_discard got=%h exp=504", ip_b); end
        step();
        step();
        vecs++; if (ip_b !== 32'h50C) begin errs++; $display("FAIL redir_run got=%h exp=50c", ip_b); end
    endtask

    task automatic test_wrap_reset();
        redirect_to(32'hFFFF_FFFC);
        vecs++; if (pcd_b !== 32'h0) begin errs++; $display("FAIL wrap_pcdef got=%h exp=0", pcd_b); end
        op = NOP;
        step();
        vecs++; if (ip_b !== 32'h0) begin errs++; $display("FAIL wrap_ip got=%h exp=0", ip_b); end
        op = JAL; up_amt = 32'h40;
        step();
        op = NOP;
        vecs++; if (fv_b !== 1'b0) begin errs++; $display("FAIL wrap_wait got=%b exp=0", fv_b); end
        rst = 1'b1;
        #1;
        vecs++; if (ip_b !== 32'h100 || fv_b !== 1'b0) begin errs++; $display("FAIL async_rst got=%h/%b exp=100/0", ip_b, fv_b); end
        step();
        vecs++; if (fv_a !== 1'b0 || ip_a !== 32'h100) begin errs++; $display("FAIL rst_hold got=%h/%b exp=100/0", ip_a, fv_a); end
        rst = 1'b0;
        #1;
        vecs++; if (fv_b !== 1'b1) begin errs++; $display("FAIL rst_release got=%b exp=1", fv_b); end
        step();
        vecs++; if (ip_b !== 32'h104) begin errs++; $display("FAIL rst_resume got=%h exp=104", ip_b); end
    endtask

    initial begin
        test_reset();
        test_branch(1'b1, 32'h1F8);
        test_branch(1'b0, 32'h204);
        test_jalr_fault();
        test_hold();
        test_redirect_hold();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
